// File: rtl/spi_counter_tx.sv
// SPI mode-0 master that sends a 14-bit counter value as two bytes (low, then high)
// inside one chip-select frame, capturing miso into rx_data for each byte.
module spi_counter_tx #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        start_LSB,
  input  logic        start_MSB,
  input  logic [13:0] count_data,
  input  logic        miso,
  output logic        ready,
  output logic        done,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic [7:0]  rx_data
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StHold, StShiftLo, StShiftHi} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic [13:0]     snap_q, snap_d;
  logic            msb_q, msb_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            cs_n_q, cs_n_d;
  logic            done_q, done_d;
  logic            accept_lsb, accept_msb, phase_end;

  // The done cycle already sits in IDLE/HOLD but must not accept a new request.
  assign accept_lsb = start & start_LSB & (state_q == StIdle) & ~done_q;
  assign accept_msb = start & start_MSB & (state_q == StHold) & ~done_q;
  assign phase_end  = (div_q == DivLast);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    snap_d    = snap_q;
    msb_d     = msb_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept_lsb) begin
          snap_d  = count_data;
          tx_d    = count_data[7:0];
          mosi_d  = count_data[7];
          cs_n_d  = 1'b0;
          msb_d   = 1'b0;
          div_d   = '0;
          bit_d   = 3'd0;
          state_d = StShiftLo;
        end
      end
      StHold: begin
        if (accept_msb) begin
          tx_d    = {2'b00, snap_q[13:8]};
          mosi_d  = 1'b0;
          msb_d   = 1'b1;
          div_d   = '0;
          bit_d   = 3'd0;
          state_d = StShiftLo;
        end
      end
      StShiftLo: begin
        if (phase_end) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], miso};
          state_d = StShiftHi;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StShiftHi: begin
        if (phase_end) begin
          div_d  = '0;
          sclk_d = 1'b0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            done_d    = 1'b1;
            rx_data_d = rx_sh_q;
            cs_n_d    = msb_q;
            state_d   = msb_q ? StIdle : StHold;
          end else begin
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
            state_d = StShiftLo;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_q     <= 3'd0;
      tx_q      <= 8'h00;
      rx_sh_q   <= 8'h00;
      rx_data_q <= 8'h00;
      snap_q    <= 14'h0000;
      msb_q     <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      snap_q    <= snap_d;
      msb_q     <= msb_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      done_q    <= done_d;
    end
  end

  assign ready   = ((state_q == StIdle) || (state_q == StHold)) && !done_q;
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_counter_tx.sv
// Bench for spi_counter_tx: frame-level model of byte order, snapshot, latency and slave echo.
module tb_spi_counter_tx;

  localparam int unsigned Div = 2;

  logic        clk = 1'b0;
  logic        reset, start, start_LSB, start_MSB, miso;
  logic [13:0] count_data;
  logic        ready, done, sclk, mosi, cs_n;
  logic [7:0]  rx_data;

  spi_counter_tx #(.CLK_DIV(Div)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_LSB (start_LSB),
    .start_MSB (start_MSB),
    .count_data(count_data),
    .miso      (miso),
    .ready     (ready),
    .done      (done),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .rx_data   (rx_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cs_fall  = 0;
  logic prev_cs = 1'b1;
  logic [13:0] snap_m;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (prev_cs === 1'b1 && cs_n === 1'b0) cs_fall <= cs_fall + 1;
    prev_cs <= cs_n;
  end

  task automatic clear_req();
    start = 1'b0; start_LSB = 1'b0; start_MSB = 1'b0;
  endtask

  // One byte: request, follow sclk as a mode-0 slave, check the done cycle and the cycle after.
  task automatic run_byte(input bit lsb, input logic [7:0] slave, input bit noise, input bit both);
    logic [7:0] exp_tx, got;
    int cycles, rises;
    logic prev_sclk;
    bit seen, cs_bad;
    @(negedge clk);
    start = 1'b1; start_LSB = lsb; start_MSB = !lsb || both;
    if (lsb) begin
      snap_m = count_data;
      exp_tx = count_data[7:0];
    end else begin
      exp_tx = {2'b00, snap_m[13:8]};
    end
    miso = slave[7];
    @(posedge clk); #1;
    clear_req();
    n_checks++;
    if (ready !== 1'b0 || cs_n !== 1'b0 || mosi !== exp_tx[7]) begin
      n_fail++;
      $display("FAIL accept: ready=%b cs_n=%b mosi=%b, required 0 0 %b", ready, cs_n, mosi, exp_tx[7]);
    end
    cycles = 0; rises = 0; got = 8'h00; seen = 0; cs_bad = 0;
    while (!seen && cycles < 16 * Div + 8) begin
      prev_sclk = sclk;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        start_LSB = 1'($urandom_range(0, 1));
        start_MSB = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cycles++;
      if (done === 1'b1) seen = 1;
      else begin
        if (cs_n !== 1'b0) cs_bad = 1;
        if (sclk === 1'b1 && prev_sclk === 1'b0) begin
          got = {got[6:0], mosi};
          rises++;
          if (rises < 8) miso = slave[7 - rises];
        end
      end
    end
    n_checks++;
    if (!seen || cycles != 16 * Div) begin
      n_fail++;
      $display("FAIL latency: seen=%0d cycles=%0d, required %0d", seen, cycles, 16 * Div);
    end
    n_checks++;
    if (got !== exp_tx || rises != 8) begin
      n_fail++;
      $display("FAIL mosi_byte: got=%h rises=%0d, required %h 8", got, rises, exp_tx);
    end
    n_checks++;
    if (rx_data !== slave) begin
      n_fail++;
      $display("FAIL rx_data: got=%h, required %h", rx_data, slave);
    end
    n_checks++;
    if (cs_bad || sclk !== 1'b0 || cs_n !== !lsb) begin
      n_fail++;
      $display("FAIL done_cycle: cs_bad=%0d sclk=%b cs_n=%b, required 0 0 %b", cs_bad, sclk, cs_n, !lsb);
    end
    // A request held through the done cycle must not start another byte.
    if (noise) begin
      start = 1'b1; start_LSB = 1'b1; start_MSB = 1'b1;
    end
    @(posedge clk); #1;
    clear_req();
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1 || sclk !== 1'b0 || cs_n !== !lsb) begin
      n_fail++;
      $display("FAIL after_done: done=%b ready=%b sclk=%b cs_n=%b, required 0 1 0 %b",
               done, ready, sclk, cs_n, !lsb);
    end
  endtask

  // Drives one request pattern for several cycles and expects nothing to start.
  task automatic hold_quiet(input logic s, input logic l, input logic m, input logic exp_cs,
                            input string name);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = s; start_LSB = l; start_MSB = m;
      @(posedge clk); #1;
      n_checks++;
      if (cs_n !== exp_cs || ready !== 1'b1 || sclk !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s: cs_n=%b ready=%b sclk=%b done=%b, required %b 1 0 0",
                 name, cs_n, ready, sclk, done, exp_cs);
      end
    end
    clear_req();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || sclk !== 1'b0 || mosi !== 1'b0 || cs_n !== 1'b1 ||
        rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: ready=%b done=%b sclk=%b mosi=%b cs_n=%b rx=%h, required 1 0 0 0 1 00",
               ready, done, sclk, mosi, cs_n, rx_data);
    end
  endtask

  task automatic test_ignored_requests();
    hold_quiet(1'b1, 1'b0, 1'b0, 1'b1, "idle_start_only");
    hold_quiet(1'b1, 1'b0, 1'b1, 1'b1, "idle_msb");
    hold_quiet(1'b0, 1'b1, 1'b0, 1'b1, "idle_lsb_no_start");
  endtask

  task automatic test_directed_frame();
    count_data = 14'h2A5C;
    run_byte(1'b1, 8'hC3, 1'b0, 1'b0);
    count_data = 14'h0000;
    hold_quiet(1'b1, 1'b1, 1'b0, 1'b0, "hold_lsb");
    hold_quiet(1'b1, 1'b0, 1'b0, 1'b0, "hold_start_only");
    run_byte(1'b0, 8'hC3, 1'b0, 1'b0);
  endtask

  task automatic test_both_requests();
    count_data = 14'($urandom);
    run_byte(1'b1, 8'($urandom), 1'b0, 1'b1);
    run_byte(1'b0, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_random_frames();
    int d0, c0;
    d0 = done_cnt; c0 = cs_fall;
    for (int f = 0; f < 3; f++) begin
      count_data = 14'($urandom);
      run_byte(1'b1, 8'($urandom), 1'b1, 1'b0);
      count_data = 14'($urandom);
      run_byte(1'b0, 8'($urandom), 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt - d0 != 6 || cs_fall - c0 != 3) begin
      n_fail++;
      $display("FAIL frame_count: done=%0d cs_windows=%0d, required 6 3", done_cnt - d0, cs_fall - c0);
    end
  endtask

  task automatic test_reset_mid_byte();
    int rises, cycles, d0;
    logic prev_sclk;
    count_data = 14'($urandom);
    run_byte(1'b1, 8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; start_MSB = 1'b1;
    @(posedge clk); #1;
    clear_req();
    rises = 0; cycles = 0;
    while (rises < 4 && cycles < 16 * Div) begin
      prev_sclk = sclk;
      @(posedge clk); #1;
      cycles++;
      if (sclk === 1'b1 && prev_sclk === 1'b0) rises++;
    end
    d0 = done_cnt;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (rises != 4 || cs_n !== 1'b1 || sclk !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: rises=%0d cs_n=%b sclk=%b ready=%b done=%b, required 4 1 0 1 0",
               rises, cs_n, sclk, ready, done);
    end
    repeat (20 * Div) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != d0 || cs_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_no_done: done pulses=%0d cs_n=%b, required 0 1", done_cnt - d0, cs_n);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_req();
    miso = 1'b0;
    count_data = 14'h0000;
    repeat (2) @(posedge clk);
    test_reset();
    test_ignored_requests();
    test_directed_frame();
    test_both_requests();
    test_random_frames();
    test_reset_mid_byte();
    test_ignored_requests();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
